// File: rtl/seg_scan_controller_if.sv
// Valid/ready load port for the seven-segment scan controller.
// The producer drives master and the scan controller receives on slave.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [NUM_DIGITS-1:0]   load_blank;

    modport master (
        output load_valid,
        output load_data,
        output load_blank,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_blank,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller with a double-buffered load port.
// New contents are staged in a shadow buffer and committed only on the frame wrap edge.
//
// phase    | meaning
// PH_BLANK | leading guard cycles of a slot, every anode off
// PH_ON    | selected digit lit with its decoded segments
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_scan_controller_if.slave  load,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode,
    output logic                  frame_start
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    logic [IDX_W-1:0]                idx;
    logic [CNT_W-1:0]                count;
    logic [NUM_DIGITS-1:0][3:0]      shadow_data;
    logic [NUM_DIGITS-1:0]           shadow_blank;
    logic                            pending;
    logic [NUM_DIGITS-1:0][3:0]      active_data;
    logic [NUM_DIGITS-1:0]           active_blank;

    logic   slot_end;
    logic   wrap;
    logic   accept;
    logic   in_blank;
    phase_t phase;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign slot_end       = (count == CNT_W'(DWELL_CYCLES - 1));
    assign wrap           = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign load.load_ready = ~pending;
    assign accept         = load.load_valid && ~pending;

    // With no guard cycles the compare would be constant, so it is elided.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = ({{(32-CNT_W){1'b0}}, count} < 32'(BLANK_CYCLES));
        end
    endgenerate

    assign phase = in_blank ? PH_BLANK : PH_ON;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            count        <= '0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
            active_data  <= '0;
            active_blank <= '1;
            frame_start  <= 1'b0;
        end else begin
            if (slot_end) begin
                count <= '0;
                idx   <= wrap ? '0 : idx + IDX_W'(1);
            end else begin
                count <= count + CNT_W'(1);
            end

            frame_start <= wrap;

            if (wrap && pending) begin
                active_data  <= shadow_data;
                active_blank <= shadow_blank;
            end

            // accept needs pending=0 and commit needs pending=1, so they never collide
            if (accept) begin
                shadow_data  <= load.load_data;
                shadow_blank <= load.load_blank;
                pending      <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        anode   = '1;
        cathode = 7'h7F;
        if (phase == PH_ON) begin
            anode[idx] = 1'b0;
            if (!active_blank[idx]) begin
                cathode = hex7(active_data[idx]);
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for the scan controller: table-driven frame checks at defaults,
// hand-written load-hold and mid-frame reset sequences, and a small-parameter instance.
module tb_seg_scan_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [3:0] anode;
    logic [6:0] cathode;
    logic       frame_start;
    logic [1:0] anode2;
    logic [6:0] cathode2;
    logic       frame_start2;

    int checks = 0;
    int errors = 0;

    seg_scan_controller_if #(.NUM_DIGITS(4)) ld  ();
    seg_scan_controller_if #(.NUM_DIGITS(2)) ld2 ();

    seg_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(1)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .load        (ld.slave),
        .anode       (anode),
        .cathode     (cathode),
        .frame_start (frame_start)
    );

    seg_scan_controller #(.NUM_DIGITS(2), .DWELL_CYCLES(2), .BLANK_CYCLES(0)) u_small (
        .clock       (clock),
        .reset       (reset),
        .load        (ld2.slave),
        .anode       (anode2),
        .cathode     (cathode2),
        .frame_start (frame_start2)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef struct {
        logic            do_load;
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] cath;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][6:0] cath_of(input logic [15:0] d, input logic [3:0] b);
        logic [3:0][6:0] c;
        for (int i = 0; i < 4; i++) begin
            c[i] = b[i] ? 7'h7F : SEG_TAB[d[4*i +: 4]];
        end
        return c;
    endfunction

    // e = rising edges since reset release; on = new contents are committed
    task automatic chk_u1(input int e, input logic [3:0][6:0] c, input logic on,
                          input logic rdy, input string tag);
        int         ix;
        int         ct;
        logic [3:0] ea;
        logic [6:0] ec;
        ix = (e / 8) % 4;
        ct = e % 8;
        ea = 4'hF;
        ec = 7'h7F;
        if (ct >= 1) begin
            ea[ix] = 1'b0;
            if (on) ec = c[ix];
        end
        check($sformatf("%s anode e=%0d", tag, e), 32'(anode), 32'(ea));
        check($sformatf("%s cathode e=%0d", tag, e), 32'(cathode), 32'(ec));
        check($sformatf("%s frame_start e=%0d", tag, e), 32'(frame_start),
              32'((e > 0) && (e % 32 == 0)));
        check($sformatf("%s load_ready e=%0d", tag, e), 32'(ld.load_ready), 32'(rdy));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [3:0][6:0] c_fedc;
    logic [3:0][6:0] c_aaaa;
    logic [3:0][6:0] c_4321;
    logic [3:0][6:0] none;

    initial begin
        ld.load_valid  = 1'b0;
        ld.load_data   = '0;
        ld.load_blank  = '0;
        ld2.load_valid = 1'b0;
        ld2.load_data  = '0;
        ld2.load_blank = '0;

        vecs[0] = '{1'b0, 16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[1] = '{1'b1, 16'h4321, 4'b0000, {7'h4C, 7'h06, 7'h12, 7'h4F}};
        vecs[2] = '{1'b1, 16'h8888, 4'b1010, {7'h7F, 7'h00, 7'h7F, 7'h00}};
        vecs[3] = '{1'b1, 16'hFEDC, 4'b0000, {7'h38, 7'h30, 7'h42, 7'h31}};
        vecs[4] = '{1'b1, 16'hB9A5, 4'b0000, {7'h60, 7'h04, 7'h08, 7'h24}};
        vecs[5] = '{1'b1, 16'h7600, 4'b0010, {7'h0F, 7'h20, 7'h7F, 7'h01}};

        c_fedc = cath_of(16'hFEDC, 4'b0000);
        c_aaaa = cath_of(16'hAAAA, 4'b0000);
        c_4321 = cath_of(16'h4321, 4'b0000);
        none   = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

        // Reset held: outputs dark, ready high
        repeat (2) @(negedge clock);
        check("rst anode", 32'(anode), 32'hF);
        check("rst cathode", 32'(cathode), 32'h7F);
        check("rst frame_start", 32'(frame_start), 32'h0);
        check("rst load_ready", 32'(ld.load_ready), 32'h1);

        // Table-driven: load accepted on edge 5, committed on edge 32, shown in frame 2
        for (int v = 0; v < 6; v++) begin
            do_reset();
            chk_u1(0, vecs[v].cath, 1'b0, 1'b1, $sformatf("vec%0d", v));
            for (int e = 1; e <= 64; e++) begin
                step();
                chk_u1(e, vecs[v].cath, vecs[v].do_load && (e >= 32),
                       !vecs[v].do_load || (e < 5) || (e >= 32), $sformatf("vec%0d", v));
                if (e == 4 && vecs[v].do_load) begin
                    ld.load_valid = 1'b1;
                    ld.load_data  = vecs[v].data;
                    ld.load_blank = vecs[v].blank;
                end else if (e == 5) begin
                    ld.load_valid = 1'b0;
                end
            end
        end

        // Second load held off by pending, accepted after the first commit
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            step();
            chk_u1(e, (e >= 64) ? c_aaaa : c_fedc, e >= 32,
                   (e < 3) || (e == 32) || (e >= 64), "hold");
            if (e == 2) begin
                ld.load_valid = 1'b1;
                ld.load_data  = 16'hFEDC;
                ld.load_blank = 4'b0000;
            end else if (e == 3) begin
                ld.load_data  = 16'hAAAA;
            end else if (e == 33) begin
                ld.load_valid = 1'b0;
            end
        end

        // Reset during a lit slot with a load pending
        do_reset();
        for (int e = 1; e <= 42; e++) begin
            step();
            chk_u1(e, c_4321, e >= 32, (e < 5) || (e >= 32 && e < 36), "midrst");
            if (e == 4) begin
                ld.load_valid = 1'b1;
                ld.load_data  = 16'h4321;
                ld.load_blank = 4'b0000;
            end else if (e == 35) begin
                ld.load_valid = 1'b1;
                ld.load_data  = 16'h8888;
                ld.load_blank = 4'b0000;
            end else begin
                ld.load_valid = 1'b0;
            end
        end
        #2 reset = 1'b1;
        #1;
        check("midrst async anode", 32'(anode), 32'hF);
        check("midrst async cathode", 32'(cathode), 32'h7F);
        check("midrst async load_ready", 32'(ld.load_ready), 32'h1);
        check("midrst async frame_start", 32'(frame_start), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            step();
            chk_u1(e, none, 1'b0, 1'b1, "postrst");
        end

        // Small instance: 2 digits, 2-cycle dwell, no guard cycles
        do_reset();
        ld2.load_valid = 1'b1;
        ld2.load_data  = 8'h21;
        ld2.load_blank = 2'b00;
        for (int e = 0; e <= 12; e++) begin
            int ix;
            if (e > 0) step();
            if (e == 1) ld2.load_valid = 1'b0;
            ix = (e / 2) % 2;
            check($sformatf("small anode e=%0d", e), 32'(anode2),
                  (ix == 1) ? 32'h1 : 32'h2);
            check($sformatf("small cathode e=%0d", e), 32'(cathode2),
                  (e < 4) ? 32'h7F : ((ix == 1) ? 32'h12 : 32'h4F));
            check($sformatf("small frame_start e=%0d", e), 32'(frame_start2),
                  32'((e > 0) && (e % 4 == 0)));
            check($sformatf("small load_ready e=%0d", e), 32'(ld2.load_ready),
                  32'((e < 1) || (e >= 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the board's multi-digit seven-segment display. It owns the shared cathode bus and sequences the anodes so each digit gets an exclusive, ghost-free time slot. Digit values arrive from any producer, such as the memory-block select logic, through a valid/ready load port. New values are double-buffered and committed only at frame boundaries, so the display never tears mid-frame.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 2..8
- DWELL_CYCLES, 8, clock cycles per digit slot; legal 2..256
- BLANK_CYCLES, 1, leading cycles of each slot with all anodes off (ghosting guard); legal 0..DWELL_CYCLES-1
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; all registers take reset values immediately
- load_valid  in  1  producer offers new display contents
- load_ready  out  1  controller can accept a load; equals ~pending
- load_data  in  4*NUM_DIGITS  hex nibble per digit; digit i = load_data[4i+3:4i]; digit 0 is rightmost
- load_blank  in  NUM_DIGITS  1 = digit i stays dark
- anode  out  NUM_DIGITS  active-low digit enables; at most one bit low at any time
- cathode  out  7  active-low segments; bit6 = a … bit0 = g
- frame_start  out  1  one-cycle pulse marking the first cycle of a new frame

## Operation
- **State registers:**
  - idx: current digit, range 0..NUM_DIGITS-1.
  - count: cycle within slot, range 0..DWELL_CYCLES-1.
  - shadow_data, shadow_blank, pending: staging buffer.
  - active_data, active_blank: values currently displayed.
  - frame_start: registered pulse.
- **Slot phases, decoded from count:**
  - BLANK (count < BLANK_CYCLES): anode all 1s, cathode 7'h7F.
  - ON (count >= BLANK_CYCLES): anode[idx] = 0, other bits 1. cathode = decode(active_data[idx]), or 7'h7F if active_blank[idx].
- **Advance rules:**
  - Each edge: count increments.
  - At count == DWELL_CYCLES-1: count goes to 0 and idx increments.
  - At idx == NUM_DIGITS-1 with the slot ending, idx wraps to 0. This edge is the wrap edge.
- **Load handshake:**
  - Accept occurs on an edge with load_valid && load_ready.
  - On accept, shadow_data and shadow_blank capture the inputs and pending is set to 1.
  - While load_valid=1 and load_ready=0, the producer holds load_data and load_blank stable.
- **Commit:**
  - On the wrap edge, if pending=1: active_data/active_blank take the shadow values and pending clears. load_ready is high from the next cycle.
  - On the wrap edge, if pending=0: active is unchanged. An accept on that same edge goes to shadow and waits for the next wrap.
  - A second load is never accepted before the first commits. There is no overwrite.
- **frame_start:** set to 1 by the wrap edge, cleared on the next edge.
- **Hex decode (active-low, abcdefg):**
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- **Outputs:** anode and cathode are decoded from registered state only. There is no combinational path from any input to anode, cathode or frame_start.

## Timing
- **Reset values:**
  - idx=0, count=0, pending=0.
  - active_blank all 1s, active_data 0, frame_start=0.
  - Resulting outputs: anode all 1s, cathode 7'h7F, load_ready=1.
- **Reset mid-operation:** outputs go dark immediately and the shadow contents are discarded.
- **Frame period:** NUM_DIGITS*DWELL_CYCLES cycles (32 at defaults).
- **Slot lengths:** each digit is lit for DWELL_CYCLES-BLANK_CYCLES consecutive cycles (7 at defaults). With BLANK_CYCLES=0, lit slots abut with no dark cycle.
- **First wrap after reset release:** the wrap edge is the (NUM_DIGITS*DWELL_CYCLES)-th rising edge. frame_start is first high for the cycle after it. No pulse is produced at reset exit.
- **Load latency:**
  - A load is visible starting at digit 0 of the first frame whose wrap edge follows the accept.
  - Worst case: one frame plus one cycle.
  - Best case: an accept one edge before the wrap edge commits on that wrap edge.

## Test plan
- Reset, then idle 64 cycles (defaults): anode stays 4'b1111 and cathode 7'h7F for the whole period. frame_start pulses after edges 32 and 64. load_ready=1 throughout.
- Load data=16'h4321, blank=0 at cycle 5. Commit occurs at edge 32. In the next frame, digit 0 shows cathode 1001111 with anode 4'b1110 for 7 cycles, following 1 dark cycle. Digits 1..3 then show 2, 3, 4 in order.
- Load data=16'hFEDC at cycle 3, then hold load_valid with data=16'hAAAA. load_ready stays 0 until cycle 33. The second load commits at edge 64, and the frame after edge 32 shows F,E,D,C.
- blank=4'b1010 with data=16'h8888: digits 1 and 3 are dark for their whole slot. Digits 0 and 2 show cathode 7'b0000000.
- Assert reset mid-frame while a load is pending: outputs go dark immediately and load_ready becomes 1. After release, the discarded shadow never appears on the display.
- Parameter sweep NUM_DIGITS=2, DWELL_CYCLES=2, BLANK_CYCLES=0: the frame is 4 cycles. anode follows 10, 10, 01, 01 with no dark cycles, and frame_start pulses every 4 cycles.
